// File: rtl/speed2phase_if.sv
// speed2phase_if: tick/load/speed command inputs and paced phase sample outputs of speed2phase
interface speed2phase_if;
  logic tick;
  logic load;
  logic signed [15:0] speed_in;
  logic [3:0] meanlen;
  logic signed [18:0] phase;
  logic sample;
  logic win_start;
  logic sat;
  logic pending;
  modport master (output tick, load, speed_in, meanlen, input phase, sample, win_start, sat, pending);
  modport slave (input tick, load, speed_in, meanlen, output phase, sample, win_start, sat, pending);
endinterface

// File: rtl/speed2phase.sv
// speed2phase: Q5.10 speed to paced signed 19-bit phase differences with error-feedback residue
// Defining SPEED2PHASE_SLEW_EN limits each boundary speed change to SLEW_STEP.
module speed2phase #(
  parameter int unsigned GAIN = 1024,
  parameter int unsigned SHIFT = 10,
  parameter int unsigned SLEW_STEP = 64
) (
  input logic clock,
  input logic reset,
  speed2phase_if.slave bus
);
`ifdef SPEED2PHASE_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif
  localparam logic signed [16:0] G = {1'b0, 16'(GAIN)};
  // A step wider than any possible speed difference makes the change an immediate jump
  localparam logic signed [17:0] STEP = SLEW ? 18'(SLEW_STEP) : 18'sd65535;
  logic signed [15:0] speed, target, nxt;
  logic signed [17:0] sx, tx, diff;
  logic signed [32:0] prod;
  logic signed [33:0] acc, q;
  logic [20:0] res, rem;
  logic [14:0] cnt, last;
  logic [3:0] len;
  logic pend, bnd, v1, w1, hi, lo;
  assign bnd = bus.tick && cnt == 15'd0;
  assign last = 15'((32'd1 << len) - 32'd1);
  assign sx = {{2{speed[15]}}, speed};
  assign tx = {{2{target[15]}}, target};
  assign diff = tx - sx;
  assign acc = $signed({prod[32], prod}) + $signed({13'd0, res});
  assign q = acc >>> SHIFT;
  assign rem = 21'(acc - (q <<< SHIFT));
  assign hi = q > 34'sd262143;
  assign lo = q < -34'sd262144;
  assign bus.pending = pend;
  always_comb begin
    nxt = speed;
    if (bnd && pend)
      nxt = 16'(diff > STEP ? sx + STEP : diff < -STEP ? sx - STEP : tx);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      speed <= '0;
      target <= '0;
      pend <= 1'b0;
      cnt <= '0;
      len <= '0;
      v1 <= 1'b0;
      w1 <= 1'b0;
      prod <= '0;
      res <= '0;
      bus.phase <= '0;
      bus.sample <= 1'b0;
      bus.win_start <= 1'b0;
      bus.sat <= 1'b0;
    end else begin
      v1 <= bus.tick;
      w1 <= bnd;
      if (bus.tick) begin
        speed <= nxt;
        prod <= nxt * G;
        cnt <= bnd ? (bus.meanlen == 4'd0 ? 15'd0 : 15'd1) : (cnt == last ? 15'd0 : cnt + 15'd1);
        if (bnd) len <= bus.meanlen;
      end
      // A load coinciding with a boundary is kept for the next boundary
      if (bus.load) begin
        target <= bus.speed_in;
        pend <= 1'b1;
      end else if (bnd && pend && nxt == target) pend <= 1'b0;
      bus.sample <= v1;
      if (v1) begin
        bus.phase <= hi ? 19'sh3FFFF : lo ? 19'sh40000 : q[18:0];
        bus.sat <= hi || lo;
        bus.win_start <= w1;
        res <= (hi || lo) ? 21'd0 : rem;
      end
    end
  end
endmodule

// File: tb/tb_speed2phase.sv
// tb_speed2phase: three parameterisations of speed2phase driven in lockstep against an arithmetic model
module tb_speed2phase;
  localparam int G[3] = '{1024, 1, 65535};
  localparam int S[3] = '{10, 2, 0};
  typedef struct {
    int due;
    logic [2:0][18:0] ph;
    logic [2:0] sat;
    logic win;
  } exp_t;
  typedef struct {
    logic [15:0] speed;
    int exp_a;
    int exp_c;
    logic sat_c;
  } vec_t;
  logic clock = 1'b0, reset = 1'b1, tick = 1'b0, load = 1'b0;
  logic [15:0] speed_in = '0;
  logic [3:0] meanlen = '0;
  logic [2:0][18:0] ph;
  logic [2:0] smp, win, sat, pnd;
  int n_cmp = 0, n_bad = 0, edge_n = 0;
  exp_t q[$];
  int bq[$];
  int m_speed = 0, m_pend = 0, m_idx = 0, m_len = 0;
  bit m_pending = 0;
  longint mres[3] = '{0, 0, 0};
  always #5 clock = ~clock;
  speed2phase_if bi[3] ();
  for (genvar i = 0; i < 3; i++) begin : g
    assign bi[i].tick = tick;
    assign bi[i].load = load;
    assign bi[i].speed_in = speed_in;
    assign bi[i].meanlen = meanlen;
    assign ph[i] = bi[i].phase;
    assign smp[i] = bi[i].sample;
    assign win[i] = bi[i].win_start;
    assign sat[i] = bi[i].sat;
    assign pnd[i] = bi[i].pending;
    speed2phase #(.GAIN(G[i]), .SHIFT(S[i]), .SLEW_STEP(64)) dut (.clock(clock), .reset(reset), .bus(bi[i]));
  end
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
    end
  endtask
  // Reference: window position, speed and per-instance residue from the stated arithmetic
  always @(posedge clock) begin
    exp_t e;
    longint acc, d, qq;
    edge_n++;
    if (reset) begin
      q.delete();
      m_speed = 0; m_pend = 0; m_pending = 0; m_idx = 0; m_len = 0;
      for (int k = 0; k < 3; k++) mres[k] = 0;
    end else begin
      if (tick) begin
        if (m_idx == 0) begin
          if (m_pending) begin
`ifdef SPEED2PHASE_SLEW_EN
            if (m_pend > m_speed + 64) m_speed += 64;
            else if (m_pend < m_speed - 64) m_speed -= 64;
            else m_speed = m_pend;
`else
            m_speed = m_pend;
`endif
            m_pending = (m_speed != m_pend);
          end
          m_len = int'(meanlen);
        end
        e.due = edge_n + 1;
        e.win = (m_idx == 0);
        for (int k = 0; k < 3; k++) begin
          d = longint'(1) << S[k];
          acc = longint'(m_speed) * G[k] + mres[k];
          qq = acc / d;
          if (acc % d != 0 && acc < 0) qq--;
          if (qq > 262143 || qq < -262144) begin
            e.ph[k] = qq > 0 ? 19'h3FFFF : 19'h40000;
            e.sat[k] = 1'b1;
            mres[k] = 0;
          end else begin
            e.ph[k] = 19'(qq);
            e.sat[k] = 1'b0;
            mres[k] = acc - qq * d;
          end
        end
        q.push_back(e);
        m_idx = (m_idx + 1) % (1 << m_len);
      end
      if (load) begin
        m_pend = int'($signed(speed_in));
        m_pending = 1;
      end
    end
  end
  always @(negedge clock) begin
    bit hit;
    hit = q.size() > 0 && q[0].due == edge_n;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sample[%0d]", k), longint'(smp[k]), longint'(hit));
      chk($sformatf("pending[%0d]", k), longint'(pnd[k]), longint'(m_pending));
      if (hit && smp[k]) begin
        chk($sformatf("phase[%0d]", k), longint'($signed(ph[k])), longint'($signed(q[0].ph[k])));
        chk($sformatf("sat[%0d]", k), longint'(sat[k]), longint'(q[0].sat[k]));
        chk($sformatf("win_start[%0d]", k), longint'(win[k]), longint'(q[0].win));
      end
    end
    if (smp[1]) bq.push_back(int'($signed(ph[1])));
    if (hit) void'(q.pop_front());
  end
  task automatic tick_once();
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    vec_t v[8];
    int pat[16];
    int sa, sb;
    v[0] = '{16'h0400, 1024, 262143, 1'b1};
    v[1] = '{16'h7FFF, 32767, 262143, 1'b1};
    v[2] = '{16'h8000, -32768, -262144, 1'b1};
    v[3] = '{16'h0000, 0, 0, 1'b0};
    v[4] = '{16'h0003, 3, 196605, 1'b0};
    v[5] = '{16'hFFFC, -4, -262140, 1'b0};
    v[6] = '{16'h0004, 4, 262140, 1'b0};
    v[7] = '{16'hFFFB, -5, -262144, 1'b1};
    pat = '{0, 0, 0, 1, 0, 0, 0, 1, -1, 0, 0, 0, -1, 0, 0, 0};
    repeat (3) @(negedge clock);
    chk("reset_phase", longint'($signed(ph[0])), 0);
    chk("reset_pending", longint'(pnd[0]), 0);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      load = 1'b1;
      speed_in = v[i].speed;
      @(negedge clock);
      load = 1'b0;
      tick_once();
      chk("tbl_phase_a", longint'($signed(ph[0])), v[i].exp_a);
      chk("tbl_phase_c", longint'($signed(ph[2])), v[i].exp_c);
      chk("tbl_sat_c", longint'(sat[2]), longint'(v[i].sat_c));
      chk("tbl_win_a", longint'(win[0]), 1);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    meanlen = 4'd2;
    load = 1'b1;
    speed_in = 16'h0001;
    @(negedge clock);
    load = 1'b0;
    bq.delete();
    tick = 1'b1;
    repeat (8) @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
    load = 1'b1;
    speed_in = 16'hFFFF;
    @(negedge clock);
    load = 1'b0;
    tick = 1'b1;
    repeat (8) @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
    chk("pat_count", bq.size(), 16);
    if (bq.size() == 16) begin
      for (int i = 0; i < 16; i++) chk($sformatf("pat[%0d]", i), bq[i], pat[i]);
      sa = bq[0] + bq[1] + bq[2] + bq[3];
      sb = bq[8] + bq[9] + bq[10] + bq[11];
      chk("win_sum_pos", sa, 1);
      chk("win_sum_neg", sb, -1);
    end
    meanlen = 4'd0;
    load = 1'b1;
    speed_in = 16'h0400;
    @(negedge clock);
    load = 1'b0;
    tick_once();
    chk("pre_reset_phase", longint'($signed(ph[0])), 1024);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_sample", longint'(smp[0]), 0);
    chk("rst_phase", longint'($signed(ph[0])), 0);
    chk("rst_sat_c", longint'(sat[2]), 0);
    chk("rst_win", longint'(win[0]), 0);
    reset = 1'b0;
    tick_once();
    chk("post_rst_win", longint'(win[0]), 1);
    chk("post_rst_phase", longint'($signed(ph[0])), 0);
    for (int c = 0; c < 4000; c++) begin
      tick = $urandom_range(0, 3) != 0;
      load = $urandom_range(0, 24) == 0;
      case ($urandom_range(0, 3))
        0: speed_in = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        1: speed_in = 16'($urandom);
        default: speed_in = 16'($signed($urandom_range(0, 600)) - 300);
      endcase
      if ($urandom_range(0, 99) == 0) meanlen = 4'($urandom_range(0, 5));
      reset = $urandom_range(0, 799) == 0;
      @(negedge clock);
    end
    tick = 1'b0;
    load = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
